// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcode enum, FIFO entry layout and
// the opcode legality helper.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned REG_AW = 4;

    typedef enum logic [CTRL_W-1:0] {
        AluAdd  = 5'd1,
        AluSub  = 5'd2,
        AluMul  = 5'd3,
        AluMove = 5'd4,
        AluAnd  = 5'd9,
        AluOr   = 5'd10,
        AluXor  = 5'd11,
        AluNot  = 5'd12
    } alu_op_e;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              b_is_imm;
        logic [REG_AW-1:0] rd;
        logic              we;
    } issue_entry_t;

    function automatic logic is_legal_op(input logic [CTRL_W-1:0] op);
        case (op)
            AluAdd, AluSub, AluMul, AluMove,
            AluAnd, AluOr, AluXor, AluNot: is_legal_op = 1'b1;
            default:                       is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand at capture: r0 reads zero, then MEM result,
// then WB write, then register-file data.
module operand_fwd_mux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_val,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_val,
    output logic [DATA_W-1:0] val
);

    always_comb begin
        if (idx == '0) begin
            val = '0;
        end else if (mem_we && (mem_rd == idx)) begin
            val = mem_val;
        end else if (wb_we && (wb_rd == idx)) begin
            val = wb_val;
        end else begin
            val = reg_val;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: 2-entry in-order skid FIFO in front of the ALU with
// capture-time forwarding and WB snooping. Define ALU_ISSUE_ILLEGAL_TRAP_EN for illegal_op.
module alu_issue_stage
    import alu_pkg::issue_entry_t, alu_pkg::is_legal_op;
#(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned CTRL_W = alu_pkg::CTRL_W,
    parameter int unsigned REG_AW = alu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_alu_ctrl,
    input  logic [REG_AW-1:0] in_rs1_idx,
    input  logic [REG_AW-1:0] in_rs2_idx,
    input  logic [DATA_W-1:0] in_rs1_val,
    input  logic [DATA_W-1:0] in_rs2_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rd_idx,
    input  logic              in_we,
    input  logic              fwd_mem_we,
    input  logic [REG_AW-1:0] fwd_mem_rd,
    input  logic [DATA_W-1:0] fwd_mem_val,
    input  logic              fwd_wb_we,
    input  logic [REG_AW-1:0] fwd_wb_rd,
    input  logic [DATA_W-1:0] fwd_wb_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] src_a,
    output logic [DATA_W-1:0] src_b,
    output logic [REG_AW-1:0] out_rd_idx,
    output logic              out_we
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    ,
    output logic              illegal_op
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} fifo_state_e;

    fifo_state_e  state_q, state_d;
    issue_entry_t head_q, head_d, tail_q, tail_d;
    issue_entry_t head_snp, tail_snp, new_entry;
    logic [DATA_W-1:0] rs1_res, rs2_res;
    logic accept, pop, head_kept;

    function automatic issue_entry_t snoop(input issue_entry_t e, input logic we,
                                           input logic [REG_AW-1:0] rd,
                                           input logic [DATA_W-1:0] val);
        issue_entry_t s;
        s = e;
        if (we && (rd != '0)) begin
            if (e.rs1 == rd) s.a = val;
            if (!e.b_is_imm && (e.rs2 == rd)) s.b = val;
        end
        return s;
    endfunction

    operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
        .idx     (in_rs1_idx),
        .reg_val (in_rs1_val),
        .mem_we  (fwd_mem_we),
        .mem_rd  (fwd_mem_rd),
        .mem_val (fwd_mem_val),
        .wb_we   (fwd_wb_we),
        .wb_rd   (fwd_wb_rd),
        .wb_val  (fwd_wb_val),
        .val     (rs1_res)
    );

    operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
        .idx     (in_rs2_idx),
        .reg_val (in_rs2_val),
        .mem_we  (fwd_mem_we),
        .mem_rd  (fwd_mem_rd),
        .mem_val (fwd_mem_val),
        .wb_we   (fwd_wb_we),
        .wb_rd   (fwd_wb_rd),
        .wb_val  (fwd_wb_val),
        .val     (rs2_res)
    );

    // Flush swallows the incoming op, so it never counts as an accept.
    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StEmpty;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StOne;
            StOne: begin
                if (accept && !pop)      state_d = StFull;
                else if (pop && !accept) state_d = StEmpty;
            end
            StFull:  if (pop) state_d = StOne;
            default: state_d = StEmpty;
        endcase
        if (flush) state_d = StEmpty;
    end

    always_comb begin
        in_ready   = rst_n && (state_q != StFull);
        out_valid  = (state_q != StEmpty);
        alu_ctrl   = out_valid ? head_q.ctrl : '0;
        src_a      = out_valid ? head_q.a    : '0;
        src_b      = out_valid ? head_q.b    : '0;
        out_rd_idx = out_valid ? head_q.rd   : '0;
        out_we     = out_valid ? head_q.we   : 1'b0;
    end

    always_comb begin
        new_entry.ctrl     = in_alu_ctrl;
        new_entry.a        = rs1_res;
        new_entry.b        = in_use_imm ? in_imm : rs2_res;
        new_entry.rs1      = in_rs1_idx;
        new_entry.rs2      = in_rs2_idx;
        new_entry.b_is_imm = in_use_imm;
        new_entry.rd       = in_rd_idx;
        new_entry.we       = in_we;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        if (!is_legal_op(in_alu_ctrl)) begin
            new_entry.ctrl = '0;
            new_entry.we   = 1'b0;
        end
`endif
    end

    // Resident entries snoop WB; the fresh entry already saw WB through the mux.
    always_comb begin
        head_snp  = snoop(head_q, fwd_wb_we, fwd_wb_rd, fwd_wb_val);
        tail_snp  = snoop(tail_q, fwd_wb_we, fwd_wb_rd, fwd_wb_val);
        head_kept = (state_q == StFull) || ((state_q == StOne) && !pop);
        head_d    = pop ? tail_snp : head_snp;
        tail_d    = tail_snp;
        if (accept) begin
            if (head_kept) tail_d = new_entry;
            else           head_d = new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= accept && !is_legal_op(in_alu_ctrl);
    end

    assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_alu_ctrl;
    logic [3:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_use_imm, in_we;
    logic        fwd_mem_we, fwd_wb_we;
    logic [3:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_val, fwd_wb_val;
    logic        out_valid, out_ready;
    logic [4:0]  alu_ctrl;
    logic [31:0] src_a, src_b;
    logic [3:0]  out_rd_idx;
    logic        out_we;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic        illegal_op;
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_ctrl (in_alu_ctrl),
        .in_rs1_idx  (in_rs1_idx),
        .in_rs2_idx  (in_rs2_idx),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .in_rd_idx   (in_rd_idx),
        .in_we       (in_we),
        .fwd_mem_we  (fwd_mem_we),
        .fwd_mem_rd  (fwd_mem_rd),
        .fwd_mem_val (fwd_mem_val),
        .fwd_wb_we   (fwd_wb_we),
        .fwd_wb_rd   (fwd_wb_rd),
        .fwd_wb_val  (fwd_wb_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_ctrl    (alu_ctrl),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_rd_idx  (out_rd_idx),
        .out_we      (out_we)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        ,
        .illegal_op  (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        bit          b_imm;
        logic [3:0]  rd;
        bit          we;
    } op_t;

    op_t q[$];
    bit  ill_exp = 1'b0;
    bit  last_accept = 1'b0;
    int  errors = 0;
    int  checks = 0;
    int  legal_ops[8] = '{1, 2, 3, 4, 9, 10, 11, 12};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [4:0] c);
        foreach (legal_ops[i]) if (c == 5'(legal_ops[i])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] resolve(input logic [3:0] idx, input logic [31:0] regv);
        if (idx == 0) return 32'd0;
        if (fwd_mem_we && fwd_mem_rd == idx) return fwd_mem_val;
        if (fwd_wb_we && fwd_wb_rd == idx) return fwd_wb_val;
        return regv;
    endfunction

    // One clock: compare outputs at the falling edge, then advance the model.
    task automatic cycle();
        op_t e, h;
        bit  vld, acc, pp, ill_next;
        @(negedge clk);
        vld = (q.size() > 0);
        h = '{default: '0};
        if (vld) h = q[0];
        check("out_valid", out_valid, vld);
        check("in_ready", in_ready, rst_n && q.size() < 2);
        check("alu_ctrl", alu_ctrl, h.ctrl);
        check("src_a", src_a, h.a);
        check("src_b", src_b, h.b);
        check("out_rd_idx", out_rd_idx, h.rd);
        check("out_we", out_we, h.we);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        check("illegal_op", illegal_op, ill_exp);
`endif
        acc = rst_n && !flush && in_valid && q.size() < 2;
        pp  = rst_n && !flush && vld && out_ready;
        e.ctrl  = in_alu_ctrl;
        e.a     = resolve(in_rs1_idx, in_rs1_val);
        e.b     = in_use_imm ? in_imm : resolve(in_rs2_idx, in_rs2_val);
        e.rs1   = in_rs1_idx;
        e.rs2   = in_rs2_idx;
        e.b_imm = in_use_imm;
        e.rd    = in_rd_idx;
        e.we    = in_we;
        ill_next = acc && !legal(in_alu_ctrl);
        if (Trap && !legal(in_alu_ctrl)) begin
            e.ctrl = 5'd0;
            e.we   = 1'b0;
        end
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (fwd_wb_we && fwd_wb_rd != 0) begin
                foreach (q[i]) begin
                    if (q[i].rs1 == fwd_wb_rd) q[i].a = fwd_wb_val;
                    if (!q[i].b_imm && q[i].rs2 == fwd_wb_rd) q[i].b = fwd_wb_val;
                end
            end
            if (acc) q.push_back(e);
        end
        ill_exp = rst_n && ill_next;
        last_accept = acc;
        #1;
    endtask

    task automatic set_op(input logic [4:0] c, input logic [3:0] r1, input logic [31:0] v1,
                          input logic [3:0] r2, input logic [31:0] v2, input bit ui,
                          input logic [31:0] im, input logic [3:0] rd, input bit we);
        in_valid    = 1'b1;
        in_alu_ctrl = c;
        in_rs1_idx  = r1;
        in_rs1_val  = v1;
        in_rs2_idx  = r2;
        in_rs2_val  = v2;
        in_use_imm  = ui;
        in_imm      = im;
        in_rd_idx   = rd;
        in_we       = we;
    endtask

    task automatic fwd_off();
        fwd_mem_we = 1'b0; fwd_mem_rd = '0; fwd_mem_val = '0;
        fwd_wb_we  = 1'b0; fwd_wb_rd  = '0; fwd_wb_val  = '0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_op(5'd0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0);
        in_valid = 1'b0;
        fwd_off();
        repeat (2) @(posedge clk);
        #1;
        cycle();
        check("reset_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        cycle();

        // ADD r1(1) + r2(5)
        out_ready = 1'b1;
        set_op(5'd1, 4'd1, 32'd1, 4'd2, 32'd5, 1'b0, 32'd0, 4'd6, 1'b1);
        cycle();
        in_valid = 1'b0;
        check("add_valid", out_valid, 1'b1);
        check("add_src_a", src_a, 32'd1);
        check("add_src_b", src_b, 32'd5);
        cycle();
        cycle();

        // SUB r3 with MEM and WB both hitting r3: MEM wins; imm operand
        set_op(5'd2, 4'd3, 32'd100, 4'd5, 32'd77, 1'b1, 32'd1, 4'd7, 1'b1);
        fwd_mem_we = 1'b1; fwd_mem_rd = 4'd3; fwd_mem_val = 32'd2;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 4'd3; fwd_wb_val  = 32'd9;
        cycle();
        in_valid = 1'b0;
        fwd_off();
        check("sub_src_a", src_a, 32'd2);
        check("sub_src_b", src_b, 32'd1);
        cycle();

        // Stall: MUL, MOVE fill the buffer; AND held upstream; WB snoops
        out_ready = 1'b0;
        set_op(5'd3, 4'd2, 32'd2, 4'd4, 32'd8, 1'b0, 32'd0, 4'd8, 1'b1);
        cycle();
        set_op(5'd4, 4'd15, 32'd15, 4'd0, 32'd0, 1'b0, 32'd0, 4'd9, 1'b1);
        cycle();
        check("full_in_ready", in_ready, 1'b0);
        set_op(5'd9, 4'd1, 32'd1, 4'd6, 32'd1, 1'b0, 32'd0, 4'd10, 1'b1);
        cycle();
        fwd_wb_we = 1'b1; fwd_wb_rd = 4'd4; fwd_wb_val = 32'd7;
        cycle();
        check("snoop_src_b", src_b, 32'd7);
        fwd_wb_rd = 4'd0; fwd_wb_val = 32'd123;
        cycle();
        fwd_off();
        check("r0_snoop_src_a", src_a, 32'd2);
        out_ready = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_accept && n < 8);
        check("and_accepted", last_accept, 1'b1);
        in_valid = 1'b0;
        repeat (3) cycle();

        // Flush a full buffer while OR is offered
        out_ready = 1'b0;
        set_op(5'd1, 4'd1, 32'd3, 4'd2, 32'd4, 1'b0, 32'd0, 4'd1, 1'b1);
        cycle();
        set_op(5'd11, 4'd3, 32'd5, 4'd4, 32'd6, 1'b0, 32'd0, 4'd2, 1'b1);
        cycle();
        set_op(5'd10, 4'd0, 32'd0, 4'd1, 32'd1, 1'b0, 32'd0, 4'd3, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        cycle();

        // Reset mid-stall
        set_op(5'd1, 4'd1, 32'd3, 4'd2, 32'd4, 1'b0, 32'd0, 4'd1, 1'b1);
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        check("rst_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        cycle();

        // Opcode 7
        out_ready = 1'b1;
        set_op(5'd7, 4'd1, 32'd1, 4'd2, 32'd2, 1'b0, 32'd0, 4'd5, 1'b1);
        cycle();
        in_valid = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        check("illegal_pulse", illegal_op, 1'b1);
        check("illegal_ctrl", alu_ctrl, 5'd0);
        check("illegal_we", out_we, 1'b0);
`else
        check("op7_ctrl", alu_ctrl, 5'd7);
        check("op7_we", out_we, 1'b1);
`endif
        cycle();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(63) != 0);
            flush = ($urandom_range(15) == 0);
            out_ready = ($urandom_range(3) != 0);
            set_op(($urandom_range(3) == 0) ? 5'($urandom_range(31))
                                            : 5'(legal_ops[$urandom_range(7)]),
                   4'($urandom_range(7)), $urandom, 4'($urandom_range(7)), $urandom,
                   1'($urandom_range(1)), $urandom, 4'($urandom_range(15)),
                   1'($urandom_range(1)));
            in_valid    = 1'($urandom_range(1));
            fwd_mem_we  = 1'($urandom_range(1));
            fwd_mem_rd  = 4'($urandom_range(7));
            fwd_mem_val = $urandom;
            fwd_wb_we   = 1'($urandom_range(1));
            fwd_wb_rd   = 4'($urandom_range(7));
            fwd_wb_val  = $urandom;
            cycle();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fwd_off();
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the 32-bit ALU (alu_ctrl 5b, srcA, srcB).
- Accepts decoded micro-ops from decode, resolves operands through MEM/WB forwarding, and buffers up to 2 ops in an in-order skid FIFO.
- Presents registered alu_ctrl/src_a/src_b to the ALU under a valid/ready handshake.
- Snoops WB writes while ops are resident, so stalled operands never go stale.

Parameters:
- DATA_W, 32, operand width.
- CTRL_W, 5, ALU control width.
- REG_AW, 4, register index width; index 0 reads as zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all buffered ops
- in_valid  in  1  decode op valid
- in_ready  out  1  stage can accept
- in_alu_ctrl  in  CTRL_W  opcode (ADD=1 SUB=2 MUL=3 MOVE=4 AND=9 OR=10 XOR=11 NOT=12)
- in_rs1_idx, in_rs2_idx  in  REG_AW  source indices
- in_rs1_val, in_rs2_val  in  DATA_W  register-file read data
- in_imm  in  DATA_W  immediate
- in_use_imm  in  1  src_b := imm
- in_rd_idx  in  REG_AW  destination
- in_we  in  1  op writes rd
- fwd_mem_we, fwd_mem_rd, fwd_mem_val  in  1/REG_AW/DATA_W  MEM-stage result
- fwd_wb_we, fwd_wb_rd, fwd_wb_val  in  1/REG_AW/DATA_W  WB-stage write
- out_valid  out  1  head op valid to ALU
- out_ready  in  1  ALU/EX consumes
- alu_ctrl  out  CTRL_W  to ALU
- src_a, src_b  out  DATA_W  to ALU
- out_rd_idx  out  REG_AW
- out_we  out  1

Behaviour:
- Reset (rst_n=0 at posedge): state EMPTY. All outputs 0, including in_ready. From the first cycle after release, in_ready=1.
- FIFO state machine, 2 entries, in-order: EMPTY -> ONE -> FULL.
  - in_ready = (state!=FULL).
  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
  - EMPTY: accept -> ONE.
  - ONE: accept & ~pop -> FULL; pop & ~accept -> EMPTY; both -> ONE, with new op as head next cycle.
  - FULL: pop -> ONE. No accept possible.
- Latency: an op accepted at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1) when the FIFO was empty or head was popped.
- Output fields always come from registered head entry. When out_valid=0, alu_ctrl/src/out_we = 0.
- Operand resolution at capture, per source (rs1; rs2 only if ~in_use_imm):
  - idx==0 -> 0.
  - Else fwd_mem_we & fwd_mem_rd==idx -> fwd_mem_val.
  - Else fwd_wb_we & fwd_wb_rd==idx -> fwd_wb_val.
  - Else the register-file value.
  - MEM has priority over WB.
- in_use_imm: src_b = in_imm. The stored rs2 is marked "no snoop".
- Snoop: every cycle, each resident entry replaces a stored operand whose idx!=0 and matches fwd_wb_rd when fwd_wb_we=1. This applies to the head being popped in the same cycle only if it is not popped.
- Capture and snoop in the same cycle: capture-time resolution already includes WB; no double apply.
- flush: at the edge, state -> EMPTY, in_valid ignored that cycle, pending pop ignored. Flush takes priority over accept/pop. rst_n has priority over flush.
- out_valid held with fields stable until out_ready, except snoop updates to src_a/src_b (allowed, documented for EX).
- EX-stage (in-ALU) producer hazards are decode's responsibility; not detected here.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined: adds output illegal_op (1b, reset 0).
  - An accepted op whose alu_ctrl is not in {1,2,3,4,9,10,11,12} is stored with alu_ctrl=0 and we=0.
  - illegal_op pulses 1 for one cycle after the accept edge.
- Undefined: no port. Opcodes pass through unchanged.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum with the eight opcodes above.
  - CTRL_W constant.
  - issue_entry_t struct {ctrl, a, b, rs1, rs2, b_is_imm, rd, we}.
  - Function is_legal_op.
- One sub-module, operand_fwd_mux: combinational idx/regval -> resolved value with MEM/WB priority, instantiated twice for capture. Snoop logic stays inline.

Test Plan:
- ADD rs1=r1(1), rs2=r2(5), out_ready=1 -> next cycle out_valid=1, alu_ctrl=1, src_a=1, src_b=5; then out_valid=0.
- SUB r3, fwd_mem_rd=3 val=2 and fwd_wb_rd=3 val=9 same cycle, rs2 imm=1 -> src_a=2, src_b=1.
- out_ready=0, push MUL(2,8), MOVE(15), AND(1,1) -> in_ready=0 after 2nd accept, 3rd held upstream. Release -> MUL, MOVE, AND issued in order, no loss or duplication.
- MUL stalled with rs2=r4 (reg val 8), then fwd_wb r4=7 while stalled -> src_b becomes 7 before pop. r0 write snoop ignored.
- FULL buffer, flush=1 with in_valid=1 OR(0,1) -> next cycle out_valid=0, in_ready=1, OR dropped. Reset mid-stall gives identical result with in_ready=0 during reset.
- With ALU_ISSUE_ILLEGAL_TRAP_EN: alu_ctrl=5'd7 -> illegal_op=1 one cycle, issued alu_ctrl=0, out_we=0. Without the macro: alu_ctrl=7 passed through.
